muldiv_seq: RTL

- Multi-cycle sequencer that executes MULT/MULTU/DIV/DIVU by time-multiplexing the shared 32-bit ALU. Each step uses the ALU for exactly one add or subtract.
- Sits beside the execute stage. The pipeline issues an operation with start, stalls on busy, and reads hi/lo when done pulses.
- While busy, the block owns the ALU operand/op mux. When idle, the pipeline owns it.

---
 rtl/muldiv_seq_pkg.sv | 30 +++
 rtl/muldiv_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - ALU opcodes understood by the shared execute-stage ALU (ADDU, SUBU)
//   - 2-bit muldiv operation encodings presented on muldiv_seq.op
//   - sequencer state encodings (7 states in 3 bits)
package muldiv_seq_pkg;

  localparam int ALU_OP_W = 4;

  // Opcodes of the shared ALU; only these two are ever driven by the sequencer.
  localparam logic [ALU_OP_W-1:0] ALU_ADDU = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUBU = 4'h1;

  // op[1] selects divide, op[0] selects signed.
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_ITER   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared 32-bit
// ALU for one add or subtract per step. Signed operations are done on
// magnitudes and the result sign is fixed up at the end, so the sequence
// length is the same (37 cycles start-to-done) for every operation.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, op, rs, rt  request (sampled only in IDLE); operands latched at accept
//   busy               high while the sequencer is working (ABS_A..FIX_HI)
//   done               one-cycle pulse; hi/lo valid from this cycle and held
//   hi, lo             product[63:32]/[31:0] or remainder/quotient
//   alu_req            sequencer owns the ALU this cycle (equals busy)
//   alu_a, alu_b, alu_op  ALU operand/opcode requests
//   alu_out            combinational ALU result for the current operands
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    rs,
  input  logic [WIDTH-1:0]    rt,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output logic                alu_req,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    alu_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e         state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;          // rs, then |rs|
  logic [WIDTH-1:0]  b_q, b_d;          // rt, then |rt|
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;  // negate quotient / product
  logic              neg_rem_q, neg_rem_d;  // negate remainder
  logic              lo_zero_q, lo_zero_d;  // borrow into hi when negating a 64-bit product
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  alu_a_s, alu_b_s;
  logic [ALU_OP_W-1:0] alu_op_s;

  // Divide step helpers: shifted partial remainder and its dropped msb.
  logic [WIDTH-1:0]  div_r_s;
  logic              div_msb_s;
  logic              div_take_s;
  // Multiply step helpers: accumulated high half and carry out of it.
  logic [WIDTH-1:0]  mul_sum_s;
  logic              mul_carry_s;

  // Next-state, datapath updates and ALU operand requests.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    lo_zero_d   = lo_zero_q;
    alu_a_s     = {WIDTH{1'b0}};
    alu_b_s     = {WIDTH{1'b0}};
    alu_op_s    = ALU_ADDU;
    div_r_s     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    div_msb_s   = hi_q[WIDTH-1];
    div_take_s  = 1'b0;
    mul_sum_s   = hi_q;
    mul_carry_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ABS_A;
          op_d      = op;
          a_d       = rs;
          b_d       = rt;
          cnt_d     = {CNT_W{1'b0}};
          neg_quo_d = op[0] & (rs[WIDTH-1] ^ rt[WIDTH-1]);
          neg_rem_d = op[0] & rs[WIDTH-1];
          lo_zero_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Magnitude of rs: 0 - rs for a negative signed operand, else 0 + rs.
      ST_ABS_A: begin
        alu_b_s  = a_q;
        alu_op_s = (op_q[0] & a_q[WIDTH-1]) ? ALU_SUBU : ALU_ADDU;
        a_d      = alu_out;
        state_d  = ST_ABS_B;
      end

      // Magnitude of rt, then seed {hi,lo}: {0,b} for multiply, {0,a} for divide.
      ST_ABS_B: begin
        alu_b_s  = b_q;
        alu_op_s = (op_q[0] & b_q[WIDTH-1]) ? ALU_SUBU : ALU_ADDU;
        b_d      = alu_out;
        hi_d     = {WIDTH{1'b0}};
        if (op_q[1]) begin
          lo_d = a_q;
        end else begin
          lo_d = alu_out;
        end
        state_d  = ST_ITER;
      end

      ST_ITER: begin
        if (op_q[1]) begin
          // Restoring divide: subtract when the 33-bit remainder >= divisor.
          alu_a_s    = div_r_s;
          alu_b_s    = b_q;
          alu_op_s   = ALU_SUBU;
          div_take_s = div_msb_s | ~(div_r_s < b_q);
          hi_d       = div_take_s ? alu_out : div_r_s;
          lo_d       = {lo_q[WIDTH-2:0], div_take_s};
        end else begin
          // Shift-add multiply; the ALU has no carry out, so recover it here.
          alu_a_s  = hi_q;
          alu_b_s  = a_q;
          alu_op_s = ALU_ADDU;
          if (lo_q[0]) begin
            mul_sum_s   = alu_out;
            mul_carry_s = (alu_out < hi_q);
          end else begin
            mul_sum_s   = hi_q;
            mul_carry_s = 1'b0;
          end
          hi_d = {mul_carry_s, mul_sum_s[WIDTH-1:1]};
          lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX_LO;
        end else begin
          state_d = ST_ITER;
        end
      end

      // Negate the low word; for a product remember whether it was zero,
      // since that is the only case in which the negation borrows into hi.
      ST_FIX_LO: begin
        alu_b_s   = lo_q;
        alu_op_s  = ALU_SUBU;
        lo_zero_d = (lo_q == {WIDTH{1'b0}});
        if (neg_quo_q) begin
          lo_d = alu_out;
        end else begin
          lo_d = lo_q;
        end
        state_d   = ST_FIX_HI;
      end

      ST_FIX_HI: begin
        if (op_q[1]) begin
          alu_b_s  = hi_q;
          alu_op_s = ALU_SUBU;
          if (neg_rem_q) begin
            hi_d = alu_out;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          // High half of a 64-bit two's complement: ~hi + (lo was zero).
          alu_a_s  = ~hi_q;
          alu_b_s  = {{(WIDTH-1){1'b0}}, lo_zero_q};
          alu_op_s = ALU_ADDU;
          if (neg_quo_q) begin
            hi_d = alu_out;
          end else begin
            hi_d = hi_q;
          end
        end
        state_d = ST_DONE;
      end

      // start is deliberately not sampled here.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_ABS_A) || (state_d == ST_ABS_B) || (state_d == ST_ITER) ||
             (state_d == ST_FIX_LO) || (state_d == ST_FIX_HI);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULTU;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      lo_zero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      lo_zero_q <= lo_zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign alu_req = busy_q;
  // ALU requests derive only from registered state, so there is no
  // combinational loop through the external ALU.
  assign alu_a   = alu_a_s;
  assign alu_b   = alu_b_s;
  assign alu_op  = alu_op_s;

endmodule
